btn_irq_ctrl: RTL and testbench
===============================

Name: btn_irq_ctrl

Overview:
- Receiving end of the board push-button lines (BTNU/BTNL/BTNR/BTND/BTNC) and the source of a CPU hardware-interrupt request line.
- Synchronises and debounces each button, then detects edges and latches them as pending interrupt bits.
- Exposes status, pending, enable and edge-select registers on a simple word-addressed MMIO slave port for the MIPS core.
- Drives a level `irq` that the block design ties to one of the core's external interrupt inputs.

Parameters:
- N_BTN, 5, number of button inputs. Bit order is {BTNC, BTND, BTNR, BTNL, BTNU}, bit 0 = BTNU.
- DEBOUNCE_CYCLES, 1000000, stable-input cycles required before the debounced level changes. This is 10 ms at 100 MHz. Must be ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter.

Ports:
- clk_in  in  1  system clock (100 MHz)
- resetn  in  1  synchronous, active-low reset
- btn_in  in  N_BTN  raw asynchronous button levels, active-high
- bus_sel  in  1  MMIO access strobe, single-cycle
- bus_we  in  1  1 = write, 0 = read; valid with bus_sel
- bus_addr  in  2  word index: 0 STATUS, 1 PENDING, 2 ENABLE, 3 EDGE
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, registered
- bus_rvalid  out  1  read data valid
- irq  out  1  interrupt request, level, active-high

Behaviour:
- Reset (resetn=0 sampled at posedge clk_in):
  - Synchroniser flops, debounced levels, counters, PENDING, ENABLE and EDGE clear to 0.
  - bus_rdata=0, bus_rvalid=0, irq=0.
  - Reset mid-debounce discards partial counts; no edge is reported for a button held through reset until it is seen stable high for DEBOUNCE_CYCLES after reset.
- Synchroniser: two-flop chain per bit, giving sync[i].
- Debounce, per bit:
  - If sync[i] == db[i], the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, db[i] takes sync[i] and the counter clears.
  - Any bounce back to db[i] resets the counter, so glitches shorter than DEBOUNCE_CYCLES never propagate.
  - The counter never wraps.
- Edge detect:
  - rise[i] = db[i] & ~db_d[i]; fall[i] = ~db[i] & db_d[i] (db_d is db delayed one cycle).
  - ev[i] = EDGE[i] ? fall[i] : rise[i].
- PENDING[i]:
  - Set on ev[i].
  - Cleared by a write to addr 1 with bus_wdata[i]=1 (W1C).
  - If set and clear occur in the same cycle, set wins.
- Latency: raw input change → irq high = 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) + 1 (pending) cycles, with ENABLE set.
- irq is registered: irq <= |(PENDING_next & ENABLE_next). It deasserts the cycle after the clearing write or the disabling write.
- Registers:
  - STATUS (0), RO: {27'b0, db}. Writes are ignored.
  - PENDING (1), W1C: {27'b0, pending}.
  - ENABLE (2), RW: bits [N_BTN-1:0]. Upper bits read 0.
  - EDGE (3), RW: 0 = rising-edge event, 1 = falling-edge event.
  - Enable is not a gate on pending: disabled bits still latch, so enabling later with PENDING already set raises irq.
- Bus timing:
  - A read (bus_sel & ~bus_we) in cycle t gives bus_rdata valid with bus_rvalid=1 in cycle t+1.
  - bus_rvalid is 0 in all other cycles, and bus_rdata holds its last value.
  - Writes take effect at the posedge where they are sampled, with no response.
  - Back-to-back accesses are supported every cycle.
  - A read of PENDING returns the value before any same-cycle set.

Decomposition:
- Shared package btn_irq_pkg: register word-index constants (REG_STATUS=0, REG_PENDING=1, REG_ENABLE=2, REG_EDGE=3) and the button bit-position constants (BTN_U=0 … BTN_C=4).
- One sub-module, btn_debounce: single-bit synchroniser plus debounce counter, parameterised by DEBOUNCE_CYCLES. It is instantiated N_BTN times via generate.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset/idle: hold resetn=0 for 20 cycles, then release with btn_in=0 → irq=0; reads of addrs 0–3 return 0 with bus_rvalid exactly one cycle after bus_sel.
- Clean press: write ENABLE=5'h01, set btn_in[0]=1 and hold → STATUS reads 0x01; PENDING=0x01; irq rises 8 cycles after the input change. Then write PENDING=0x01 → irq=0 next cycle and PENDING reads 0.
- Bounce rejection: toggle btn_in[2] with a period of 3 cycles, 10 times → STATUS[2] stays 0, PENDING stays 0, irq stays 0.
- Falling-edge select: EDGE=0x10, ENABLE=0x10, btn_in[4] pulsed high for 10 cycles → no event on press; PENDING=0x10 and irq=1 only after release is debounced.
- Masked then enabled: ENABLE=0, press btn_in[1] → PENDING=0x02 with irq=0; write ENABLE=0x02 → irq=1 on the following cycle.
- Collision and reset: issue a W1C of bit 3 in the same cycle as the debounced rise of bit 3 → PENDING[3] remains 1. Assert resetn=0 while btn_in[3] is held → all registers read 0 after reset, and a new edge on bit 3 is reported only after it is stable high for 4 cycles post-reset.

Source files
------------

// File: rtl/btn_irq_pkg.sv
// Shared constants for the push-button interrupt controller: MMIO word
// indices and the board button bit positions.
package btn_irq_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_ENABLE  = 2'd2;
    localparam logic [1:0] REG_EDGE    = 2'd3;

    localparam int BTN_U = 0;
    localparam int BTN_L = 1;
    localparam int BTN_R = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;

endpackage

// File: rtl/btn_debounce.sv
// Single-bit two-flop synchroniser followed by a stable-time debouncer; the
// output level only follows the input after DEBOUNCE_CYCLES unchanged cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_in,
    input  logic resetn,
    input  logic btn_raw,
    output logic db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_s1;
    logic             sync_s2;
    logic [CNT_W-1:0] cnt;

    // Any return to the current level restarts the count, so short glitches vanish.
    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
            db      <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_s1 <= btn_raw;
            sync_s2 <= sync_s1;
            if (sync_s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db  <= sync_s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_irq_ctrl.sv
// Push-button interrupt controller: debounced buttons, edge-triggered pending
// bits and a level irq, with STATUS/PENDING/ENABLE/EDGE on a word MMIO port.
module btn_irq_ctrl
    import btn_irq_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk_in,
    input  logic             resetn,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             bus_sel,
    input  logic             bus_we,
    input  logic [1:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             bus_rvalid,
    output logic             irq
);

    logic [N_BTN-1:0] db;
    logic [N_BTN-1:0] db_d;
    logic [N_BTN-1:0] ev;
    logic [N_BTN-1:0] ev_q;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] enable;
    logic [N_BTN-1:0] edge_sel;
    logic [N_BTN-1:0] pending_next;
    logic [N_BTN-1:0] enable_next;
    logic [N_BTN-1:0] w1c_mask;
    logic             wr_pending;
    logic             wr_enable;
    logic             wr_edge;
    logic             rd_req;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_in (clk_in),
            .resetn (resetn),
            .btn_raw(btn_in[i]),
            .db     (db[i])
        );
    end

    assign ev = (edge_sel & ~db & db_d) | (~edge_sel & db & ~db_d);

    // Bus: a sampled read (bus_sel & ~bus_we) returns data with bus_rvalid one
    // cycle later; writes commit at the sampling edge and produce no response.
    assign rd_req     = bus_sel & ~bus_we;
    assign wr_pending = bus_sel & bus_we & (bus_addr == REG_PENDING);
    assign wr_enable  = bus_sel & bus_we & (bus_addr == REG_ENABLE);
    assign wr_edge    = bus_sel & bus_we & (bus_addr == REG_EDGE);

    assign unused_wdata = ^bus_wdata[31:N_BTN];

    // A same-cycle event re-sets a bit that the W1C is clearing.
    always_comb begin
        w1c_mask     = wr_pending ? bus_wdata[N_BTN-1:0] : '0;
        pending_next = (pending & ~w1c_mask) | ev_q;
        enable_next  = wr_enable ? bus_wdata[N_BTN-1:0] : enable;
    end

    always_comb begin
        rd_word = '0;
        case (bus_addr)
            REG_STATUS:  rd_word = {{(32-N_BTN){1'b0}}, db};
            REG_PENDING: rd_word = {{(32-N_BTN){1'b0}}, pending};
            REG_ENABLE:  rd_word = {{(32-N_BTN){1'b0}}, enable};
            REG_EDGE:    rd_word = {{(32-N_BTN){1'b0}}, edge_sel};
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            db_d       <= '0;
            ev_q       <= '0;
            pending    <= '0;
            enable     <= '0;
            edge_sel   <= '0;
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
            irq        <= 1'b0;
        end else begin
            db_d       <= db;
            ev_q       <= ev;
            pending    <= pending_next;
            enable     <= enable_next;
            irq        <= |(pending_next & enable_next);
            bus_rvalid <= rd_req;
            if (wr_edge) begin
                edge_sel <= bus_wdata[N_BTN-1:0];
            end
            if (rd_req) begin
                bus_rdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Directed bench for btn_irq_ctrl with a short debounce window; reads push
// expected data into a queue that a negedge monitor pops and compares.
module tb_btn_irq_ctrl;
    import btn_irq_pkg::*;

    localparam int N_BTN = 5;
    localparam int DB    = 4;

    logic             clk_in;
    logic             resetn;
    logic [N_BTN-1:0] btn_in;
    logic             bus_sel;
    logic             bus_we;
    logic [1:0]       bus_addr;
    logic [31:0]      bus_wdata;
    logic [31:0]      bus_rdata;
    logic             bus_rvalid;
    logic             irq;

    logic [31:0] exp_q[$];
    logic [1:0]  addr_q[$];
    logic        rd_sampled;
    int          checks;
    int          errors;

    btn_irq_ctrl #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk_in    (clk_in),
        .resetn    (resetn),
        .btn_in    (btn_in),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_rvalid(bus_rvalid),
        .irq       (irq)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // driver tasks; the cursor always sits 1 time unit after a posedge
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus_sel   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = addr;
        bus_wdata = data;
        tick(1);
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = '0;
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp);
        bus_sel  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = addr;
        exp_q.push_back(exp);
        addr_q.push_back(addr);
        tick(1);
        bus_sel  = 1'b0;
    endtask

    task automatic check_irq(input logic exp, input string name);
        checks++;
        if (irq !== exp) begin
            errors++;
            $display("FAIL irq_%s: irq=%b expected %b at %0t", name, irq, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(posedge clk_in) rd_sampled <= bus_sel & ~bus_we & resetn;

    always @(negedge clk_in) begin
        logic [31:0] exp;
        logic [1:0]  a;
        if (bus_rvalid === 1'b1 || rd_sampled === 1'b1) begin
            checks++;
            if (bus_rvalid !== rd_sampled) begin
                errors++;
                $display("FAIL rvalid: bus_rvalid=%b expected %b at %0t", bus_rvalid, rd_sampled, $time);
            end
        end
        if (bus_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: bus_rdata=%h with no read outstanding at %0t", bus_rdata, $time);
            end else begin
                exp = exp_q.pop_front();
                a   = addr_q.pop_front();
                checks++;
                if (bus_rdata !== exp) begin
                    errors++;
                    $display("FAIL rd_addr%0d: bus_rdata=%h expected %h at %0t", a, bus_rdata, exp, $time);
                end
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        btn_in    = '0;
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        checks    = 0;
        errors    = 0;

        // reset and idle reads
        tick(20);
        check_irq(1'b0, "in_reset");
        resetn = 1'b1;
        tick(2);
        check_irq(1'b0, "idle");
        for (int a = 0; a < 4; a++) bus_read(2'(a), 32'h0);
        tick(2);

        // clean press on BTNU: irq 8 cycles after the input change
        bus_write(REG_ENABLE, 32'h01);
        btn_in[BTN_U] = 1'b1;
        tick(7);
        check_irq(1'b0, "press_early");
        tick(1);
        check_irq(1'b1, "press_latency");
        bus_read(REG_STATUS, 32'h01);
        bus_read(REG_PENDING, 32'h01);
        bus_write(REG_PENDING, 32'h01);
        check_irq(1'b0, "after_w1c");
        bus_read(REG_PENDING, 32'h00);
        btn_in[BTN_U] = 1'b0;
        tick(10);
        bus_read(REG_STATUS, 32'h00);

        // bounce rejection on BTNR: 3-cycle runs never reach 4 stable cycles
        bus_write(REG_ENABLE, 32'h04);
        for (int i = 0; i < 10; i++) begin
            btn_in[BTN_R] = ~btn_in[BTN_R];
            tick(3);
            check_irq(1'b0, "bounce");
        end
        tick(8);
        bus_read(REG_STATUS, 32'h00);
        bus_read(REG_PENDING, 32'h00);
        check_irq(1'b0, "bounce_end");

        // falling-edge select on BTNC
        bus_write(REG_EDGE, 32'h10);
        bus_write(REG_ENABLE, 32'h10);
        bus_read(REG_EDGE, 32'h10);
        bus_read(REG_ENABLE, 32'h10);
        btn_in[BTN_C] = 1'b1;
        tick(9);
        check_irq(1'b0, "fall_on_press");
        tick(1);
        btn_in[BTN_C] = 1'b0;
        tick(7);
        check_irq(1'b0, "fall_early");
        tick(1);
        check_irq(1'b1, "fall_release");
        bus_read(REG_PENDING, 32'h10);
        bus_read(REG_STATUS, 32'h00);
        bus_write(REG_PENDING, 32'h10);
        check_irq(1'b0, "fall_cleared");

        // masked then enabled on BTNL
        bus_write(REG_ENABLE, 32'h00);
        btn_in[BTN_L] = 1'b1;
        tick(8);
        check_irq(1'b0, "masked");
        bus_read(REG_PENDING, 32'h02);
        bus_write(REG_ENABLE, 32'h02);
        check_irq(1'b1, "enabled_late");
        bus_write(REG_PENDING, 32'h02);
        check_irq(1'b0, "masked_cleared");
        btn_in[BTN_L] = 1'b0;
        tick(10);

        // W1C colliding with the set of BTND: set wins
        bus_write(REG_ENABLE, 32'h08);
        btn_in[BTN_D] = 1'b1;
        tick(7);
        bus_write(REG_PENDING, 32'h08);
        check_irq(1'b1, "collision");
        bus_read(REG_PENDING, 32'h08);

        // reset with BTND held: new edge only after 4 stable cycles post-reset
        resetn = 1'b0;
        tick(3);
        check_irq(1'b0, "reset_held");
        resetn = 1'b1;
        bus_read(REG_STATUS, 32'h00);
        bus_read(REG_PENDING, 32'h00);
        bus_read(REG_ENABLE, 32'h00);
        bus_read(REG_EDGE, 32'h00);
        bus_write(REG_ENABLE, 32'h08);
        tick(2);
        check_irq(1'b0, "post_reset_early");
        bus_read(REG_PENDING, 32'h00);
        check_irq(1'b1, "post_reset_edge");
        bus_read(REG_PENDING, 32'h08);
        bus_read(REG_STATUS, 32'h08);
        btn_in[BTN_D] = 1'b0;

        tick(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_drain: %0d reads never answered, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
